// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiplier/divider family: widths, FSM encoding
// and the carry-lookahead helper used by cla_full_adder.
package mult_div_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = WIDTH / 2;
  localparam int ACC_W = WIDTH + 2;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Carry into bit k of a 4-bit group, written in sum-of-products lookahead form.
  function automatic logic cla_carry(input logic [3:0] g, input logic [3:0] p,
                                     input logic ci, input int k);
    logic c;
    logic t;
    c = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j < k) begin
        t = g[j];
        for (int l = 0; l < 4; l++) begin
          if (l > j && l < k) t = t & p[l];
        end
        c = c | t;
      end
    end
    t = ci;
    for (int l = 0; l < 4; l++) begin
      if (l < k) t = t & p[l];
    end
    return c | t;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoding: triplet {q[2i+1], q[2i], q[2i-1]} selects 0, +-M or
// +-2M as a 34-bit addend; negative terms are inverted with carry-in 1.
module booth_recoder
  import mult_div_pkg::*;
(
  input  logic [2:0]       triplet_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [ACC_W-1:0] addend_o,
  output logic             cin_o
);

  logic [ACC_W-1:0] m_ext;
  logic [ACC_W-1:0] m2_ext;

  assign m_ext  = {{2{mcand_i[WIDTH-1]}}, mcand_i};
  assign m2_ext = {mcand_i[WIDTH-1], mcand_i, 1'b0};

  always_comb begin
    addend_o = '0;
    cin_o    = 1'b0;
    unique case (triplet_i)
      3'b001, 3'b010: addend_o = m_ext;
      3'b011:         addend_o = m2_ext;
      3'b100: begin
        addend_o = ~m2_ext;
        cin_o    = 1'b1;
      end
      3'b101, 3'b110: begin
        addend_o = ~m_ext;
        cin_o    = 1'b1;
      end
      default: begin
        addend_o = '0;
        cin_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cla_full_adder.sv
// Carry-lookahead adder built from 4-bit lookahead groups; group carries are
// chained, so any WIDTH works (the last group may be narrower).
module cla_full_adder
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 34
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o
);

  localparam int NG = (WIDTH + 3) / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    gc;

  assign g     = a_i & b_i;
  assign p     = a_i ^ b_i;
  assign gc[0] = cin_i;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam int LO   = gi * 4;
    localparam int GWID = ((WIDTH - LO) < 4) ? (WIDTH - LO) : 4;
    logic [3:0] gg;
    logic [3:0] pp;

    assign gg = 4'(g[LO +: GWID]);
    assign pp = 4'(p[LO +: GWID]);

    for (genvar bi = 0; bi < GWID; bi++) begin : g_bit
      assign c[LO + bi] = cla_carry(gg, pp, gc[gi], bi);
    end

    if (gi < NG - 1) begin : g_next
      assign gc[gi + 1] = cla_carry(gg, pp, gc[gi], 4);
    end
  end

  assign sum_o = p ^ c;

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-4 Booth multiplier: 16 add/shift steps over a 34-bit upper
// accumulator and 32-bit lower register, then a one-cycle result pulse.
module booth_mult
  import mult_div_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             result_ready,
  output logic [WIDTH-1:0] product,
  output logic             exception
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [ACC_W-1:0] addend;
  logic             add_cin;
  logic [ACC_W-1:0] sum;
  logic [WIDTH:0]   hi_bits;

  booth_recoder u_recoder (
    .triplet_i ({lo_q[1:0], qm1_q}),
    .mcand_i   (mcand_q),
    .addend_o  (addend),
    .cin_o     (add_cin)
  );

  cla_full_adder #(
    .WIDTH (ACC_W)
  ) u_adder (
    .a_i   (acc_q),
    .b_i   (addend),
    .cin_i (add_cin),
    .sum_o (sum)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    qm1_d     = qm1_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    hi_bits   = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = multiplicand;
          lo_d    = multiplier;
          qm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Arithmetic shift of the combined {acc, lo} right by two after the add.
        acc_d = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
        lo_d  = {sum[1:0], lo_q[WIDTH-1:2]};
        qm1_d = lo_q[1];
        if (cnt_q == LAST_ITER) begin
          state_d   = DONE;
          rdy_d     = 1'b1;
          product_d = lo_d;
          // Result bits [63:31] must be a pure sign extension to fit in 32 bits.
          hi_bits   = {acc_d[WIDTH-1:0], lo_d[WIDTH-1]};
          exc_d     = ~((&hi_bits) | ~(|hi_bits));
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      qm1_q     <= 1'b0;
      mcand_q   <= '0;
      product_q <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      qm1_q     <= qm1_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign result_ready = rdy_q;
  assign product      = product_q;
  assign exception    = exc_q;

endmodule
